// File: rtl/spm_drv_pkg.sv
// Shared types and sizing helpers for the serial-parallel multiplier driver.
package spm_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bit counter must reach 2*width, hence the +1.
    function automatic int CNT_W(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/spm_drv_deser.sv
// Serial-in/parallel-out capture register; bits arrive LSB first and shift in from the top.
module spm_drv_deser #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         din,
    output logic [N-1:0] dout
);

    logic [N-1:0] data_reg;
    logic [N-1:0] data_next;

    assign data_next[N-1] = din;

    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_shift
            assign data_next[gi] = data_reg[gi+1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
        end else if (shift_en) begin
            data_reg <= data_next;
        end
    end

    assign dout = data_reg;

endmodule

// File: rtl/spm_drv.sv
// Host-side driver for a serial-parallel multiplier: serializes y, collects the product.
// Define SPM_DRV_SIGNED_EN for two's-complement operands (y is sign-padded).
module spm_drv
    import spm_drv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SPM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    input  logic               spm_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int              CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(2 * WIDTH - 1);
    localparam logic [CW-1:0]   LAT_C    = CW'(SPM_LAT);
    localparam logic [2:0]      DRAIN_LAST = 3'(SPM_LAT - 1);

    state_e             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic [2:0]         drain_reg;
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   y_reg;
    logic               pad_reg;
    logic               armed_reg;
    logic               pad_in;
    logic               accept;
    logic               cap_en;

`ifdef SPM_DRV_SIGNED_EN
    assign pad_in = in_y[WIDTH-1];
`else
    assign pad_in = 1'b0;
`endif

    // armed_reg keeps in_ready low until the first edge after reset release.
    assign in_ready  = armed_reg && (state_reg == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign spm_x     = x_reg;
    assign spm_y     = (state_reg == SHIFT) && y_reg[0];

    // Product bit j shows up SPM_LAT cycles after y bit j, so capture lags the shift.
    assign cap_en = ((state_reg == SHIFT) && (cnt_reg >= LAT_C)) || (state_reg == DRAIN);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept) state_next = SHIFT;
            SHIFT: if (cnt_reg == CNT_LAST) state_next = (SPM_LAT == 0) ? DONE : DRAIN;
            DRAIN: if (drain_reg == DRAIN_LAST) state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            drain_reg <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            pad_reg   <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            armed_reg <= 1'b1;
            if (accept) begin
                x_reg   <= in_x;
                y_reg   <= in_y;
                pad_reg <= pad_in;
                cnt_reg <= '0;
            end else if (state_reg == SHIFT) begin
                cnt_reg <= cnt_reg + CW'(1);
                y_reg   <= {pad_reg, y_reg[WIDTH-1:1]};
            end
            if (state_reg == DRAIN) begin
                drain_reg <= drain_reg + 3'd1;
            end else begin
                drain_reg <= '0;
            end
        end
    end

    spm_drv_deser #(
        .N(2 * WIDTH)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .shift_en (cap_en),
        .din      (spm_p),
        .dout     (out_p)
    );

endmodule

// File: doc/spm_drv.md
SPM_DRV -- requirements
Module: spm_drv

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal range 4..64.
REQ-002 Parameter SPM_LAT, default 1: cycles from spm_y bit k driven to spm_p bit k valid; legal range 0..4.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 in_valid  input  1  host operand pair valid.
REQ-006 in_ready  output  1  block accepts an operand pair.
REQ-007 in_x  input  WIDTH  parallel multiplicand.
REQ-008 in_y  input  WIDTH  multiplier, to be serialized.
REQ-009 spm_x  output  WIDTH  parallel operand to the spm; held constant for the whole operation.
REQ-010 spm_y  output  1  serial multiplier bit to the spm, LSB first.
REQ-011 spm_p  input  1  serial product bit from the spm, LSB first.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  host accepts the result.
REQ-014 out_p  output  2*WIDTH  parallel product.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, DRAIN and DONE.
REQ-016 IDLE: in_ready=1; when in_valid=1, the block SHALL latch in_x into spm_x and in_y into the y shift register, clear the bit counter, and go to SHIFT.
REQ-017 In SHIFT, spm_y SHALL drive y bit cnt for cnt<WIDTH and the pad bit for WIDTH<=cnt<2*WIDTH; the counter SHALL increment each cycle.
REQ-018 spm_p SHALL be sampled into bit j of out_p on the cycle j+SPM_LAT after SHIFT entry, for j=0..2*WIDTH-1.
REQ-019 After 2*WIDTH SHIFT cycles, the FSM SHALL go to DRAIN for SPM_LAT cycles, or straight to DONE if SPM_LAT=0; spm_y=0 in DRAIN.
REQ-020 DONE: out_valid=1 and out_p SHALL stay stable until out_ready=1; on that handshake the FSM SHALL go to IDLE.
REQ-021 Accept-to-out_valid latency SHALL be exactly 2*WIDTH+SPM_LAT+1 cycles.
REQ-022 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored.
REQ-023 out_p SHALL equal in_x*in_y modulo 2^(2*WIDTH), given a correct spm.
REQ-024 When out_ready is held high, the next accept SHALL occur no earlier than the cycle after the DONE handshake.

Reset
REQ-025 While rst=0: state=IDLE, in_ready=0, out_valid=0, spm_y=0, spm_x=0, out_p=0, counter=0.
REQ-026 in_ready SHALL first go to 1 in the cycle after rst deasserts.
REQ-027 Reset asserted during SHIFT, DRAIN or DONE SHALL discard the operation; no out_valid SHALL follow.

Configuration
REQ-028 Macro SPM_DRV_SIGNED_EN defined: the pad bit SHALL be in_y[WIDTH-1], and out_p is the two's-complement product.
REQ-029 Macro SPM_DRV_SIGNED_EN undefined: the pad bit SHALL be 0, and operands are unsigned.

Structure
REQ-030 Package spm_drv_pkg SHALL hold the state enum and a CNT_W constant function returning clog2(2*WIDTH+1).
REQ-031 Sub-module spm_drv_deser SHALL implement the 2*WIDTH serial-in/parallel-out capture register with a shift enable.

Verification (WIDTH=8, SPM_LAT=1, reference spm instantiated)
REQ-032 Accept x=3, y=5 -> out_p=0x000F, out_valid exactly 18 cycles after the accept.
REQ-033 Accept x=0xFF, y=0xFF -> out_p=0xFE01.
REQ-034 out_ready low for 10 cycles in DONE -> out_valid and out_p held stable, in_ready=0 throughout.
REQ-035 rst=0 pulse at SHIFT cycle 5 -> all outputs at reset values; the next operation x=2, y=7 -> out_p=0x000E.
REQ-036 SPM_DRV_SIGNED_EN defined, x=0xFF, y=0xFF (-1 * -1) -> out_p=0x0001; x=0x80, y=0x02 -> out_p=0xFF00.
REQ-037 Back-to-back: in_valid and out_ready held high for 3 operations -> each accept occurs one cycle after the previous DONE handshake, and all products are correct.
